// File: rtl/gba_mul_pkg.sv
// Shared types and constants for the multiply sequencer: FSM states, the
// early-termination bound and the internal-cycle counter width.
package gba_mul_pkg;

  localparam int MUL_M_MAX = 4;
  localparam int CNT_W     = 3;
  localparam int IDX_W     = 4;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [IDX_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WB_LO = 2'd2,
    ST_WB_HI = 2'd3
  } mul_state_e;

  // Decoded instruction fields held for the whole operation.
  typedef struct packed {
    logic     a;
    logic     u;
    logic     long_op;
    logic     s;
    reg_idx_t rd;
    reg_idx_t rdhi;
    reg_idx_t rdlo;
  } mul_op_t;

  // Internal-cycle count: m booth steps, plus one for accumulate, plus one for long.
  function automatic cnt_t exec_cycles(input cnt_t m, input logic a, input logic long_op);
    return m + cnt_t'(a) + cnt_t'(long_op);
  endfunction

endpackage

// File: rtl/mul_sequencer_if.sv
// Issue handshake between the execute stage (master) and the multiply
// sequencer (slave): request, decoded operands, cancel and status.
interface mul_sequencer_if;
  import gba_mul_pkg::*;

  logic        start;
  logic        ready;
  logic        a_flag;
  logic        u_flag;
  logic        long_mul;
  logic        s_flag;
  reg_idx_t    rd_idx;
  reg_idx_t    rdhi_idx;
  reg_idx_t    rdlo_idx;
  logic [31:0] rm_data;
  logic [31:0] rs_data;
  logic [31:0] rn_data;
  logic [3:0]  cpsr_flags;
  logic        flush;
  logic        busy;
  logic        done;

  modport master (
    output start, a_flag, u_flag, long_mul, s_flag, rd_idx, rdhi_idx, rdlo_idx,
           rm_data, rs_data, rn_data, cpsr_flags, flush,
    input  ready, busy, done
  );

  modport slave (
    input  start, a_flag, u_flag, long_mul, s_flag, rd_idx, rdhi_idx, rdlo_idx,
           rm_data, rs_data, rn_data, cpsr_flags, flush,
    output ready, busy, done
  );

endinterface

// File: rtl/mul_early_term.sv
// Early-termination step count m (1..4) from the Rs operand: the multiplier
// stops once the remaining high bytes are pure sign (or zero) extension.
module mul_early_term
  import gba_mul_pkg::*;
(
  input  logic [31:0] rs,
  input  logic        is_signed,
  output cnt_t        m
);

  logic ext_8, ext_16, ext_24;

  // All-ones counts as extension only for signed long operations.
  assign ext_8  = ~|rs[31:8]  | (is_signed & (&rs[31:8]));
  assign ext_16 = ~|rs[31:16] | (is_signed & (&rs[31:16]));
  assign ext_24 = ~|rs[31:24] | (is_signed & (&rs[31:24]));

  always_comb begin
    if (ext_8)       m = cnt_t'(1);
    else if (ext_16) m = cnt_t'(2);
    else if (ext_24) m = cnt_t'(3);
    else             m = cnt_t'(MUL_M_MAX);
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle controller around the external combinational multiplier:
// holds the pipeline, fetches the long accumulator and writes results back.
module mul_sequencer
  import gba_mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  mul_sequencer_if.slave    iss,
  output reg_idx_t          rf_raddr_a,
  output reg_idx_t          rf_raddr_b,
  input  logic [31:0]       rf_rdata_a,
  input  logic [31:0]       rf_rdata_b,
  output logic              mul_a,
  output logic              mul_u,
  output logic              mul_long,
  output logic [31:0]       mul_rm,
  output logic [31:0]       mul_rs,
  output logic [31:0]       mul_rn,
  output logic [31:0]       mul_rdhi,
  output logic [31:0]       mul_rdlo,
  output logic [3:0]        mul_cpsr,
  input  logic [31:0]       mul_lo,
  input  logic [31:0]       mul_hi,
  input  logic [3:0]        mul_flags,
  output logic              rf_we,
  output reg_idx_t          rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              flags_we,
  output logic [3:0]        flags_out
);

  mul_state_e  state_q, state_d;
  cnt_t        cnt_q;
  cnt_t        m_val;
  mul_op_t     op_q;
  logic [31:0] rm_q, rs_q, rn_q;
  logic [3:0]  cpsr_q;
  logic [31:0] acc_hi_q, acc_lo_q;
  logic        acc_fetch_q;
  logic [31:0] res_lo_q, res_hi_q;
  logic [3:0]  res_flags_q;

  logic accept, exec_last, final_wb;

  mul_early_term u_early_term (
    .rs        (iss.rs_data),
    .is_signed (iss.u_flag & iss.long_mul),
    .m         (m_val)
  );

  assign accept    = (state_q == ST_IDLE) & iss.start & ~iss.flush;
  assign exec_last = (state_q == ST_EXEC) & (cnt_q == cnt_t'(1));
  assign final_wb  = ((state_q == ST_WB_LO) & ~op_q.long_op) | (state_q == ST_WB_HI);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (iss.start) state_d = ST_EXEC;
      ST_EXEC:  if (cnt_q == cnt_t'(1)) state_d = ST_WB_LO;
      ST_WB_LO: state_d = op_q.long_op ? ST_WB_HI : ST_IDLE;
      ST_WB_HI: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (iss.flush) state_d = ST_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the operand and result latches are reset too, so the multiplier
  // inputs and write data are defined zeros straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      op_q        <= '0;
      rm_q        <= '0;
      rs_q        <= '0;
      rn_q        <= '0;
      cpsr_q      <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      acc_fetch_q <= 1'b0;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
      res_flags_q <= '0;
    end else begin
      if (accept) begin
        cnt_q       <= exec_cycles(m_val, iss.a_flag, iss.long_mul);
        op_q        <= '{a: iss.a_flag, u: iss.u_flag, long_op: iss.long_mul, s: iss.s_flag,
                         rd: iss.rd_idx, rdhi: iss.rdhi_idx, rdlo: iss.rdlo_idx};
        rm_q        <= iss.rm_data;
        rs_q        <= iss.rs_data;
        rn_q        <= iss.rn_data;
        cpsr_q      <= iss.cpsr_flags;
        acc_fetch_q <= iss.a_flag & iss.long_mul;
      end else if (state_q == ST_EXEC) begin
        cnt_q <= cnt_q - cnt_t'(1);
      end
      if ((state_q == ST_EXEC) && acc_fetch_q) begin
        acc_hi_q    <= rf_rdata_a;
        acc_lo_q    <= rf_rdata_b;
        acc_fetch_q <= 1'b0;
      end
      if (exec_last) begin
        res_lo_q    <= mul_lo;
        res_hi_q    <= mul_hi;
        res_flags_q <= mul_flags;
      end
    end
  end

  // Accumulator read port is only addressed during the first EXEC cycle.
  assign rf_raddr_a = ((state_q == ST_EXEC) && acc_fetch_q) ? op_q.rdhi : '0;
  assign rf_raddr_b = ((state_q == ST_EXEC) && acc_fetch_q) ? op_q.rdlo : '0;

  assign mul_a    = op_q.a;
  assign mul_u    = op_q.u;
  assign mul_long = op_q.long_op;
  assign mul_rm   = rm_q;
  assign mul_rs   = rs_q;
  assign mul_rn   = rn_q;
  assign mul_rdhi = acc_hi_q;
  assign mul_rdlo = acc_lo_q;
  assign mul_cpsr = cpsr_q;

  always_comb begin
    rf_waddr = '0;
    rf_wdata = '0;
    unique case (state_q)
      ST_WB_LO: begin
        rf_waddr = op_q.long_op ? op_q.rdlo : op_q.rd;
        rf_wdata = res_lo_q;
      end
      ST_WB_HI: begin
        rf_waddr = op_q.rdhi;
        rf_wdata = res_hi_q;
      end
      default: ;
    endcase
  end

  assign rf_we     = ((state_q == ST_WB_LO) | (state_q == ST_WB_HI)) & ~iss.flush;
  assign iss.done  = final_wb & ~iss.flush;
  assign flags_we  = iss.done & op_q.s;
  assign flags_out = iss.done ? res_flags_q : 4'h0;
  assign iss.busy  = (state_q != ST_IDLE);
  assign iss.ready = (state_q == ST_IDLE) & ~iss.flush;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with a behavioural multiplier and a small
// register-file model supplying accumulator reads.
module tb_mul_sequencer;

  logic        clk;
  logic        rst_n;
  logic [3:0]  rf_raddr_a, rf_raddr_b;
  logic [31:0] rf_rdata_a, rf_rdata_b;
  logic        mul_a, mul_u, mul_long;
  logic [31:0] mul_rm, mul_rs, mul_rn, mul_rdhi, mul_rdlo;
  logic [3:0]  mul_cpsr;
  logic [31:0] mul_lo, mul_hi;
  logic [3:0]  mul_flags;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        flags_we;
  logic [3:0]  flags_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf_model [16];

  mul_sequencer_if iss ();

  mul_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .iss        (iss),
    .rf_raddr_a (rf_raddr_a),
    .rf_raddr_b (rf_raddr_b),
    .rf_rdata_a (rf_rdata_a),
    .rf_rdata_b (rf_rdata_b),
    .mul_a      (mul_a),
    .mul_u      (mul_u),
    .mul_long   (mul_long),
    .mul_rm     (mul_rm),
    .mul_rs     (mul_rs),
    .mul_rn     (mul_rn),
    .mul_rdhi   (mul_rdhi),
    .mul_rdlo   (mul_rdlo),
    .mul_cpsr   (mul_cpsr),
    .mul_lo     (mul_lo),
    .mul_hi     (mul_hi),
    .mul_flags  (mul_flags),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .flags_we   (flags_we),
    .flags_out  (flags_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rf_rdata_a = rf_model[rf_raddr_a];
  assign rf_rdata_b = rf_model[rf_raddr_b];

  // Behavioural combinational multiplier: NZ from the result, CV passed through.
  logic [63:0] op_a64, op_b64, acc64, long_res;
  logic [31:0] short_res;
  always_comb begin
    op_a64    = (mul_u & mul_long) ? {{32{mul_rm[31]}}, mul_rm} : {32'd0, mul_rm};
    op_b64    = (mul_u & mul_long) ? {{32{mul_rs[31]}}, mul_rs} : {32'd0, mul_rs};
    acc64     = mul_a ? {mul_rdhi, mul_rdlo} : 64'd0;
    long_res  = op_a64 * op_b64 + acc64;
    short_res = mul_rm * mul_rs + (mul_a ? mul_rn : 32'd0);
    if (mul_long) begin
      mul_lo    = long_res[31:0];
      mul_hi    = long_res[63:32];
      mul_flags = {long_res[63], long_res == 64'd0, mul_cpsr[1:0]};
    end else begin
      mul_lo    = short_res;
      mul_hi    = 32'd0;
      mul_flags = {short_res[31], short_res == 32'd0, mul_cpsr[1:0]};
    end
  end

  typedef struct packed {
    logic        lng;
    logic        u;
    logic [31:0] rs;
    logic [3:0]  wb;
  } et_vec_t;

  et_vec_t et_tab [8] = '{
    '{1'b0, 1'b0, 32'h000000FF, 4'd2},
    '{1'b0, 1'b0, 32'h0000FFFF, 4'd3},
    '{1'b0, 1'b0, 32'h00FFFFFF, 4'd4},
    '{1'b0, 1'b0, 32'h80000000, 4'd5},
    '{1'b1, 1'b1, 32'hFFFF8000, 4'd4},
    '{1'b1, 1'b1, 32'hFF800000, 4'd5},
    '{1'b1, 1'b1, 32'h00000100, 4'd4},
    '{1'b1, 1'b0, 32'hFFFFFF00, 4'd6}
  };

  task automatic idle_inputs;
    iss.start      = 1'b0;
    iss.a_flag     = 1'b0;
    iss.u_flag     = 1'b0;
    iss.long_mul   = 1'b0;
    iss.s_flag     = 1'b0;
    iss.rd_idx     = 4'd0;
    iss.rdhi_idx   = 4'd0;
    iss.rdlo_idx   = 4'd0;
    iss.rm_data    = 32'd0;
    iss.rs_data    = 32'd0;
    iss.rn_data    = 32'd0;
    iss.cpsr_flags = 4'd0;
    iss.flush      = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of cycle 1.
  task automatic issue(input logic a, input logic u, input logic lng, input logic s,
                       input logic [3:0] rd, input logic [3:0] rdhi, input logic [3:0] rdlo,
                       input logic [31:0] rm, input logic [31:0] rs, input logic [31:0] rn,
                       input logic [3:0] cpsr);
    iss.a_flag     = a;
    iss.u_flag     = u;
    iss.long_mul   = lng;
    iss.s_flag     = s;
    iss.rd_idx     = rd;
    iss.rdhi_idx   = rdhi;
    iss.rdlo_idx   = rdlo;
    iss.rm_data    = rm;
    iss.rs_data    = rs;
    iss.rn_data    = rn;
    iss.cpsr_flags = cpsr;
    iss.start      = 1'b1;
    @(negedge clk);
    iss.start      = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (iss.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", iss.ready); end
    checks++; if (iss.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", iss.busy); end
    checks++; if (iss.done !== 1'b0 || rf_we !== 1'b0 || flags_we !== 1'b0) begin
      errors++; $display("FAIL reset_strobes got done=%b rf_we=%b flags_we=%b want 0", iss.done, rf_we, flags_we);
    end
    checks++; if (rf_waddr !== 4'd0 || rf_wdata !== 32'd0 || flags_out !== 4'd0) begin
      errors++; $display("FAIL reset_wport got %h/%h/%h want 0", rf_waddr, rf_wdata, flags_out);
    end
    checks++; if (rf_raddr_a !== 4'd0 || rf_raddr_b !== 4'd0) begin
      errors++; $display("FAIL reset_raddr got %h/%h want 0", rf_raddr_a, rf_raddr_b);
    end
    checks++; if ({mul_a, mul_u, mul_long} !== 3'b000 || mul_rm !== 32'd0 || mul_rs !== 32'd0 || mul_rdhi !== 32'd0) begin
      errors++; $display("FAIL reset_latches got ctl=%b rm=%h rs=%h rdhi=%h want 0", {mul_a, mul_u, mul_long}, mul_rm, mul_rs, mul_rdhi);
    end
  endtask

  task automatic test_mul_short;
    issue(1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd0, 4'd0, 32'd3, 32'h000000FF, 32'd0, 4'd0);
    checks++; if (iss.busy !== 1'b1 || rf_we !== 1'b0 || iss.ready !== 1'b0) begin
      errors++; $display("FAIL mul_c1 got busy=%b rf_we=%b ready=%b want 1/0/0", iss.busy, rf_we, iss.ready);
    end
    @(negedge clk);
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 4'd2 || rf_wdata !== 32'h000002FD || iss.done !== 1'b1 || flags_we !== 1'b0) begin
      errors++; $display("FAIL mul_wb got we=%b a=%h d=%h done=%b fwe=%b want 1/2/000002fd/1/0", rf_we, rf_waddr, rf_wdata, iss.done, flags_we);
    end
    @(negedge clk);
    checks++; if (iss.ready !== 1'b1 || iss.busy !== 1'b0) begin
      errors++; $display("FAIL mul_ready got ready=%b busy=%b want 1/0", iss.ready, iss.busy);
    end
  endtask

  // MLA 5*7+10 issued on the first ready cycle of the previous op.
  task automatic test_back_to_back;
    issue(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd0, 4'd0, 32'd5, 32'd7, 32'd10, 4'd0);
    @(negedge clk);
    checks++; if (rf_we !== 1'b0 || iss.busy !== 1'b1) begin
      errors++; $display("FAIL b2b_c2 got we=%b busy=%b want 0/1", rf_we, iss.busy);
    end
    @(negedge clk);
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 4'd3 || rf_wdata !== 32'h0000002D || iss.done !== 1'b1) begin
      errors++; $display("FAIL b2b_wb got we=%b a=%h d=%h done=%b want 1/3/0000002d/1", rf_we, rf_waddr, rf_wdata, iss.done);
    end
    @(negedge clk);
  endtask

  task automatic test_smull;
    issue(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd5, 4'd4, 32'hFFFFFFFF, 32'hFFFFFF00, 32'd0, 4'd0);
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL smull_c2 got we=%b want 0", rf_we); end
    @(negedge clk);
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 4'd4 || rf_wdata !== 32'h00000100 || iss.done !== 1'b0) begin
      errors++; $display("FAIL smull_lo got we=%b a=%h d=%h done=%b want 1/4/00000100/0", rf_we, rf_waddr, rf_wdata, iss.done);
    end
    @(negedge clk);
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 4'd5 || rf_wdata !== 32'h00000000 || iss.done !== 1'b1) begin
      errors++; $display("FAIL smull_hi got we=%b a=%h d=%h done=%b want 1/5/00000000/1", rf_we, rf_waddr, rf_wdata, iss.done);
    end
    @(negedge clk);
    checks++; if (iss.ready !== 1'b1) begin errors++; $display("FAIL smull_ready got %b want 1", iss.ready); end
  endtask

  task automatic test_umlal;
    rf_model[7] = 32'h00000000;
    rf_model[6] = 32'h00000001;
    issue(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd7, 4'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 4'b0001);
    checks++; if (rf_raddr_a !== 4'd7 || rf_raddr_b !== 4'd6) begin
      errors++; $display("FAIL umlal_raddr got %h/%h want 7/6", rf_raddr_a, rf_raddr_b);
    end
    @(negedge clk);
    checks++; if (rf_raddr_a !== 4'd0 || rf_raddr_b !== 4'd0) begin
      errors++; $display("FAIL umlal_raddr_c2 got %h/%h want 0/0", rf_raddr_a, rf_raddr_b);
    end
    repeat (4) @(negedge clk);
    checks++; if (rf_we !== 1'b0 || iss.busy !== 1'b1) begin
      errors++; $display("FAIL umlal_c6 got we=%b busy=%b want 0/1", rf_we, iss.busy);
    end
    @(negedge clk);
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 4'd6 || rf_wdata !== 32'h00000002 || iss.done !== 1'b0 || flags_we !== 1'b0) begin
      errors++; $display("FAIL umlal_lo got we=%b a=%h d=%h done=%b fwe=%b want 1/6/00000002/0/0", rf_we, rf_waddr, rf_wdata, iss.done, flags_we);
    end
    @(negedge clk);
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 4'd7 || rf_wdata !== 32'hFFFFFFFE || iss.done !== 1'b1) begin
      errors++; $display("FAIL umlal_hi got we=%b a=%h d=%h done=%b want 1/7/fffffffe/1", rf_we, rf_waddr, rf_wdata, iss.done);
    end
    checks++; if (flags_we !== 1'b1 || flags_out !== 4'b1001) begin
      errors++; $display("FAIL umlal_flags got we=%b nzcv=%b want 1/1001", flags_we, flags_out);
    end
    @(negedge clk);
    checks++; if (iss.ready !== 1'b1) begin errors++; $display("FAIL umlal_ready got %b want 1", iss.ready); end
  endtask

  task automatic test_muls_zero;
    issue(1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 4'd0, 32'd0, 32'h12345678, 32'd0, 4'b0010);
    repeat (3) @(negedge clk);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL muls_c4 got we=%b want 0", rf_we); end
    @(negedge clk);
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 4'd1 || rf_wdata !== 32'd0 || iss.done !== 1'b1 || flags_we !== 1'b1 || flags_out !== 4'b0110) begin
      errors++; $display("FAIL muls_wb got we=%b a=%h d=%h done=%b fwe=%b nzcv=%b want 1/1/0/1/1/0110", rf_we, rf_waddr, rf_wdata, iss.done, flags_we, flags_out);
    end
    @(negedge clk);
  endtask

  task automatic test_early_term;
    for (int i = 0; i < 8; i++) begin
      int seen;
      seen = 0;
      issue(1'b0, et_tab[i].u, et_tab[i].lng, 1'b0, 4'd1, 4'd3, 4'd2, 32'd1, et_tab[i].rs, 32'd0, 4'd0);
      for (int c = 1; c <= 12 && seen == 0; c++) begin
        if (rf_we === 1'b1) seen = c;
        else @(negedge clk);
      end
      checks++; if (seen != int'(et_tab[i].wb)) begin
        errors++; $display("FAIL early_term_%0d got wb cycle %0d want %0d", i, seen, et_tab[i].wb);
      end
      for (int c = 0; c < 12 && iss.ready !== 1'b1; c++) @(negedge clk);
      checks++; if (iss.ready !== 1'b1) begin errors++; $display("FAIL early_term_ready_%0d got %b want 1", i, iss.ready); end
    end
  endtask

  task automatic test_flush;
    issue(1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 4'd0, 4'd0, 32'd2, 32'h12345678, 32'd1, 4'd0);
    @(negedge clk);
    iss.flush = 1'b1;
    #1;
    checks++; if (rf_we !== 1'b0 || iss.done !== 1'b0 || iss.ready !== 1'b0 || iss.busy !== 1'b1) begin
      errors++; $display("FAIL flush_c2 got we=%b done=%b ready=%b busy=%b want 0/0/0/1", rf_we, iss.done, iss.ready, iss.busy);
    end
    @(negedge clk);
    iss.flush = 1'b0;
    #1;
    checks++; if (iss.ready !== 1'b1 || iss.busy !== 1'b0) begin
      errors++; $display("FAIL flush_c3 got ready=%b busy=%b want 1/0", iss.ready, iss.busy);
    end
    @(negedge clk);
    issue(1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 4'd0, 4'd0, 32'd6, 32'd7, 32'd0, 4'd0);
    @(negedge clk);
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 4'd9 || rf_wdata !== 32'd42 || iss.done !== 1'b1) begin
      errors++; $display("FAIL flush_restart got we=%b a=%h d=%h done=%b want 1/9/0000002a/1", rf_we, rf_waddr, rf_wdata, iss.done);
    end
    @(negedge clk);
    // Flush landing on the writeback cycle.
    issue(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd0, 4'd0, 32'd2, 32'd2, 32'd0, 4'd0);
    @(negedge clk);
    iss.flush = 1'b1;
    #1;
    checks++; if (rf_we !== 1'b0 || iss.done !== 1'b0 || flags_we !== 1'b0) begin
      errors++; $display("FAIL flush_wb got we=%b done=%b fwe=%b want 0/0/0", rf_we, iss.done, flags_we);
    end
    @(negedge clk);
    iss.flush = 1'b0;
    // Flush beats start while idle.
    iss.start = 1'b1;
    iss.flush = 1'b1;
    #1;
    checks++; if (iss.ready !== 1'b0) begin errors++; $display("FAIL flush_idle_ready got %b want 0", iss.ready); end
    @(negedge clk);
    checks++; if (iss.busy !== 1'b0) begin errors++; $display("FAIL flush_beats_start got busy=%b want 0", iss.busy); end
    iss.start = 1'b0;
    iss.flush = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic seen_we;
    seen_we = 1'b0;
    issue(1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 4'd0, 4'd0, 32'h11111111, 32'h12345678, 32'd5, 4'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (iss.busy !== 1'b0 || iss.ready !== 1'b1 || rf_we !== 1'b0) begin
      errors++; $display("FAIL rst_mid_state got busy=%b ready=%b we=%b want 0/1/0", iss.busy, iss.ready, rf_we);
    end
    checks++; if (mul_rm !== 32'd0 || mul_rs !== 32'd0 || mul_a !== 1'b0) begin
      errors++; $display("FAIL rst_mid_latches got rm=%h rs=%h a=%b want 0", mul_rm, mul_rs, mul_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rf_we === 1'b1 || iss.done === 1'b1) seen_we = 1'b1;
    end
    checks++; if (seen_we !== 1'b0) begin errors++; $display("FAIL rst_mid_no_wb got %b want 0", seen_we); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf_model[i] = 32'd0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_mul_short();
    test_back_to_back();
    test_smull();
    test_umlal();
    test_muls_zero();
    test_early_term();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
